// File: rtl/lighthouse_sensor_scheduler.sv
// lighthouse_sensor_scheduler: detects new per-sensor lighthouse results, queues them
// tagged with the sensor index through a round-robin arbiter into a shared FIFO, and
// exposes the queue, status and enable mask on an Avalon slave.
// Ports: clock/reset (sync, active-high); Avalon address/write/writedata/read/readdata/
// waitrequest; sensor_data_i carries sensor i's combined_data at [32*i+31:32*i].
module lighthouse_sensor_scheduler #(
  parameter int NUM_SENSORS = 9,
  parameter int FIFO_DEPTH  = 16,
  parameter int ID_W        = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [3:0]               address,
  input  logic                     write,
  input  logic [31:0]              writedata,
  input  logic                     read,
  output logic [31:0]              readdata,
  output logic                     waitrequest,
  input  logic [NUM_SENSORS*32-1:0] sensor_data_i
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int EW = ID_W + 32;
  localparam logic [31:0] EMPTY_WORD = 32'hDEAD_BEEF;

  // Per-sensor tracking
  logic [31:0]            shadow [NUM_SENSORS];
  logic [31:0]            hold   [NUM_SENSORS];
  logic [NUM_SENSORS-1:0] pending;
  logic [NUM_SENSORS-1:0] pending_next;
  logic [NUM_SENSORS-1:0] enable_mask;
  logic [NUM_SENSORS-1:0] change;
  logic [NUM_SENSORS-1:0] lost;

  // Arbiter
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] gnt_id;
  logic [ID_W-1:0] cand;
  logic            grant;

  // Lost-event counter
  logic [15:0] lost_count;
  logic [4:0]  lost_inc;
  logic [16:0] lost_sum;

  // Event FIFO
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_empty;
  logic          fifo_full;
  logic [EW-1:0] head;
  logic [ID_W-1:0] head_id;

  // Avalon decode
  logic flush;
  logic pop;

  wire unused_wdata = ^writedata[31:NUM_SENSORS];

  assign waitrequest = 1'b0;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign head       = mem[rd_ptr];
  assign head_id    = fifo_empty ? '0 : head[EW-1:32];

  assign flush = write && (address == 4'd3);
  assign pop   = read && (address == 4'd0) && !fifo_empty && !flush;

  // Round-robin search starting at rr_ptr. A flush suppresses the push.
  always_comb begin
    grant  = 1'b0;
    gnt_id = '0;
    cand   = '0;
    if (!fifo_full && !flush) begin
      for (int k = 0; k < NUM_SENSORS; k++) begin
        cand = ID_W'((int'(rr_ptr) + k) % NUM_SENSORS);
        if (!grant && pending[cand]) begin
          grant  = 1'b1;
          gnt_id = cand;
        end
      end
    end
  end

  // Change detection, pending update and loss accounting.
  // A sensor granted in the same cycle it changes again pushes the old hold value
  // and re-arms pending with the new one; that is not a loss.
  always_comb begin
    change       = '0;
    lost         = '0;
    lost_inc     = '0;
    pending_next = pending;
    for (int i = 0; i < NUM_SENSORS; i++) begin
      change[i] = (sensor_data_i[32*i +: 32] != shadow[i]);
    end
    if (grant) begin
      pending_next[gnt_id] = 1'b0;
    end
    for (int i = 0; i < NUM_SENSORS; i++) begin
      if (change[i] && enable_mask[i]) begin
        pending_next[i] = 1'b1;
        lost[i] = pending[i] && !(grant && (gnt_id == ID_W'(i)));
      end
      lost_inc = lost_inc + 5'(lost[i]);
    end
    if (flush) begin
      pending_next = '0;
    end
    lost_sum = {1'b0, lost_count} + 17'(lost_inc);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_SENSORS; i++) begin
        shadow[i] <= '0;
        hold[i]   <= '0;
      end
      pending     <= '0;
      enable_mask <= '1;
      rr_ptr      <= '0;
      lost_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      // Shadow always tracks, so re-enabling a sensor never replays a stale value.
      for (int i = 0; i < NUM_SENSORS; i++) begin
        if (change[i]) begin
          shadow[i] <= sensor_data_i[32*i +: 32];
          if (enable_mask[i] && !flush) begin
            hold[i] <= sensor_data_i[32*i +: 32];
          end
        end
      end
      pending <= pending_next;

      if (write && (address == 4'd2)) begin
        enable_mask <= writedata[NUM_SENSORS-1:0];
      end

      if (grant) begin
        rr_ptr <= (gnt_id == ID_W'(NUM_SENSORS - 1)) ? '0 : gnt_id + 1'b1;
      end

      if (flush) begin
        lost_count <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
      end else begin
        lost_count <= lost_sum[16] ? 16'hFFFF : lost_sum[15:0];
        if (grant) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        count <= count + CW'(grant) - CW'(pop);
      end
    end
  end

  // Storage needs no reset; validity is tracked by count.
  always_ff @(posedge clock) begin
    if (grant) begin
      mem[wr_ptr] <= {gnt_id, hold[gnt_id]};
    end
  end

  always_comb begin
    readdata = EMPTY_WORD;
    case (address)
      4'd0: readdata = fifo_empty ? EMPTY_WORD : head[31:0];
      4'd1: readdata = {lost_count, 8'(count), fifo_empty, fifo_full, 2'b00, 4'(head_id)};
      4'd2: readdata = 32'(enable_mask);
      4'd3: readdata = 32'h0;
      default: readdata = EMPTY_WORD;
    endcase
  end

endmodule

// File: tb/tb_lighthouse_sensor_scheduler.sv
module tb_lighthouse_sensor_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;
  logic        waitrequest;
  logic [9*32-1:0] sdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] d;

  always #5 clock = ~clock;

  lighthouse_sensor_scheduler #(
    .NUM_SENSORS(9),
    .FIFO_DEPTH(16),
    .ID_W(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .address(address),
    .write(write),
    .writedata(writedata),
    .read(read),
    .readdata(readdata),
    .waitrequest(waitrequest),
    .sensor_data_i(sdata)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic peek(input logic [3:0] a, output logic [31:0] v);
    address = a;
    #1;
    v = readdata;
  endtask

  task automatic do_pop();
    address = 4'd0;
    read = 1'b1;
    step();
    read = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] v);
    address = a;
    writedata = v;
    write = 1'b1;
    step();
    write = 1'b0;
  endtask

  task automatic set_s(input int i, input logic [31:0] v);
    sdata[32*i +: 32] = v;
  endtask

  task automatic apply_reset();
    sdata = '0;
    read = 1'b0;
    write = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    address = 4'd0; writedata = '0;
    apply_reset();
    peek(4'd1, d); checks++;
    if (d !== 32'h0000_0080) begin errors++; $display("FAIL reset_status: got %h want %h", d, 32'h0000_0080); end
    peek(4'd0, d); checks++;
    if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL reset_head: got %h want %h", d, 32'hDEAD_BEEF); end
    peek(4'd2, d); checks++;
    if (d !== 32'h0000_01FF) begin errors++; $display("FAIL reset_mask: got %h want %h", d, 32'h0000_01FF); end
    peek(4'd3, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL addr3_read: got %h want 0", d); end
    peek(4'd9, d); checks++;
    if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL addr9_read: got %h want %h", d, 32'hDEAD_BEEF); end
    checks++;
    if (waitrequest !== 1'b0) begin errors++; $display("FAIL waitrequest: got %b want 0", waitrequest); end
  endtask

  task automatic test_single();
    set_s(3, 32'h0001_2345);
    step();
    peek(4'd1, d); checks++;
    if (d !== 32'h0000_0080) begin errors++; $display("FAIL single_after1: got %h want %h", d, 32'h0000_0080); end
    step();
    peek(4'd1, d); checks++;
    if (d !== 32'h0000_0103) begin errors++; $display("FAIL single_status: got %h want %h", d, 32'h0000_0103); end
    peek(4'd0, d); checks++;
    if (d !== 32'h0001_2345) begin errors++; $display("FAIL single_head: got %h want %h", d, 32'h0001_2345); end
    do_pop();
    peek(4'd1, d); checks++;
    if (d !== 32'h0000_0080) begin errors++; $display("FAIL single_popped: got %h want %h", d, 32'h0000_0080); end
    peek(4'd0, d); checks++;
    if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_empty_head: got %h want %h", d, 32'hDEAD_BEEF); end
  endtask

  task automatic test_round_robin();
    logic [31:0] vals [3];
    logic [3:0]  ids [3];
    vals = '{32'hA0, 32'hA4, 32'hA8};
    ids  = '{4'd0, 4'd4, 4'd8};
    apply_reset();
    set_s(0, 32'hA0); set_s(4, 32'hA4); set_s(8, 32'hA8);
    step();
    for (int k = 0; k < 3; k++) begin
      step();
      peek(4'd1, d); checks++;
      if (d[15:8] !== 8'(k + 1)) begin errors++; $display("FAIL rr_count_%0d: got %0d want %0d", k, d[15:8], k + 1); end
    end
    for (int k = 0; k < 3; k++) begin
      peek(4'd1, d); checks++;
      if (d[3:0] !== ids[k]) begin errors++; $display("FAIL rr_id_%0d: got %0d want %0d", k, d[3:0], ids[k]); end
      peek(4'd0, d); checks++;
      if (d !== vals[k]) begin errors++; $display("FAIL rr_data_%0d: got %h want %h", k, d, vals[k]); end
      do_pop();
    end
    // rr_ptr has wrapped to 0 after granting sensor 8.
    set_s(0, 32'hB0); set_s(4, 32'hB4);
    step(); step(); step();
    peek(4'd1, d); checks++;
    if (d !== 32'h0000_0200) begin errors++; $display("FAIL rr2_status: got %h want %h", d, 32'h0000_0200); end
    peek(4'd0, d); checks++;
    if (d !== 32'hB0) begin errors++; $display("FAIL rr2_first: got %h want %h", d, 32'hB0); end
    do_pop();
    peek(4'd1, d); checks++;
    if (d[3:0] !== 4'd4) begin errors++; $display("FAIL rr2_second_id: got %0d want 4", d[3:0]); end
    peek(4'd0, d); checks++;
    if (d !== 32'hB4) begin errors++; $display("FAIL rr2_second: got %h want %h", d, 32'hB4); end
    do_pop();
  endtask

  task automatic test_overflow();
    logic [31:0] exp;
    apply_reset();
    for (int k = 1; k <= 20; k++) begin
      set_s(1, 32'h100 + 32'(k));
      step();
    end
    peek(4'd1, d); checks++;
    if (d !== 32'h0003_1041) begin errors++; $display("FAIL ovf_status: got %h want %h", d, 32'h0003_1041); end
    peek(4'd0, d); checks++;
    if (d !== 32'h101) begin errors++; $display("FAIL ovf_head: got %h want %h", d, 32'h101); end
    do_pop();
    peek(4'd1, d); checks++;
    if (d !== 32'h0003_0F01) begin errors++; $display("FAIL ovf_after_pop: got %h want %h", d, 32'h0003_0F01); end
    step();
    peek(4'd1, d); checks++;
    if (d !== 32'h0003_1041) begin errors++; $display("FAIL ovf_refill: got %h want %h", d, 32'h0003_1041); end
    for (int j = 0; j < 16; j++) begin
      exp = (j < 15) ? 32'h102 + 32'(j) : 32'h114;
      peek(4'd0, d); checks++;
      if (d !== exp) begin errors++; $display("FAIL ovf_drain_%0d: got %h want %h", j, d, exp); end
      do_pop();
    end
    peek(4'd1, d); checks++;
    if (d !== 32'h0003_0080) begin errors++; $display("FAIL ovf_drained: got %h want %h", d, 32'h0003_0080); end
  endtask

  task automatic test_mask();
    apply_reset();
    do_write(4'd2, 32'h1FE);
    peek(4'd2, d); checks++;
    if (d !== 32'h1FE) begin errors++; $display("FAIL mask_read: got %h want %h", d, 32'h1FE); end
    set_s(0, 32'h55);
    step(); step(); step();
    peek(4'd1, d); checks++;
    if (d !== 32'h0000_0080) begin errors++; $display("FAIL mask_blocked: got %h want %h", d, 32'h0000_0080); end
    do_write(4'd2, 32'hFFFF_FFFF);
    peek(4'd2, d); checks++;
    if (d !== 32'h1FF) begin errors++; $display("FAIL mask_upper: got %h want %h", d, 32'h1FF); end
    step(); step(); step();
    peek(4'd1, d); checks++;
    if (d !== 32'h0000_0080) begin errors++; $display("FAIL mask_no_stale: got %h want %h", d, 32'h0000_0080); end
  endtask

  task automatic test_flush();
    apply_reset();
    set_s(0, 32'h10); set_s(1, 32'h11); set_s(2, 32'h12); set_s(3, 32'h13); set_s(4, 32'h14);
    step();
    set_s(3, 32'h23);
    step();
    set_s(3, 32'h33);
    step();
    step(); step();
    set_s(6, 32'h16);
    step();
    peek(4'd1, d); checks++;
    if (d !== 32'h0002_0500) begin errors++; $display("FAIL flush_pre: got %h want %h", d, 32'h0002_0500); end
    set_s(7, 32'h17);
    read = 1'b1;
    do_write(4'd3, 32'h0);
    read = 1'b0;
    peek(4'd1, d); checks++;
    if (d !== 32'h0000_0080) begin errors++; $display("FAIL flush_now: got %h want %h", d, 32'h0000_0080); end
    step(); step(); step();
    peek(4'd1, d); checks++;
    if (d !== 32'h0000_0080) begin errors++; $display("FAIL flush_no_pending: got %h want %h", d, 32'h0000_0080); end
  endtask

  task automatic test_reset_mid();
    do_write(4'd2, 32'h02F);
    set_s(0, 32'h40); set_s(1, 32'h41); set_s(2, 32'h42); set_s(3, 32'h43);
    step();
    step(); step(); step();
    set_s(5, 32'h45);
    step();
    peek(4'd1, d); checks++;
    if (d !== 32'h0000_0400) begin errors++; $display("FAIL mid_pre: got %h want %h", d, 32'h0000_0400); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    peek(4'd1, d); checks++;
    if (d !== 32'h0000_0080) begin errors++; $display("FAIL mid_status: got %h want %h", d, 32'h0000_0080); end
    peek(4'd2, d); checks++;
    if (d !== 32'h0000_01FF) begin errors++; $display("FAIL mid_mask: got %h want %h", d, 32'h0000_01FF); end
    peek(4'd0, d); checks++;
    if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mid_head: got %h want %h", d, 32'hDEAD_BEEF); end
  endtask

  initial begin
    reset = 1'b1;
    address = '0;
    write = 1'b0;
    read = 1'b0;
    writedata = '0;
    sdata = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_overflow();
    test_mask();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
